// File: rtl/ufp_mon_pkg.sv
// Shared types and format helpers for the unsigned fixed-point threshold monitor.
// Shift amounts are derived from the sample and threshold fraction widths.
package ufp_mon_pkg;

    typedef enum logic [1:0] {
        StLow,
        StPendHi,
        StAlarm,
        StPendLo
    } mon_state_e;

    localparam int unsigned DefSampleFrac = 4;
    localparam int unsigned DefThreshFrac = 3;

    function automatic int unsigned norm_frac(input int unsigned sample_frac,
                                              input int unsigned thresh_frac);
        return (sample_frac < thresh_frac) ? sample_frac : thresh_frac;
    endfunction

    function automatic int unsigned sample_shift(input int unsigned sample_frac,
                                                 input int unsigned thresh_frac);
        return sample_frac - norm_frac(sample_frac, thresh_frac);
    endfunction

    function automatic int unsigned thresh_shift(input int unsigned sample_frac,
                                                 input int unsigned thresh_frac);
        return thresh_frac - norm_frac(sample_frac, thresh_frac);
    endfunction

    localparam int unsigned DefSampleShift = sample_shift(DefSampleFrac, DefThreshFrac);
    localparam int unsigned DefThreshShift = thresh_shift(DefSampleFrac, DefThreshFrac);

endpackage

// File: rtl/ufp_align_cmp.sv
// Combinational alignment of sample and thresholds to a common fraction width,
// followed by strict unsigned compares (equality sets neither flag).
module ufp_align_cmp
    import ufp_mon_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned SAMPLE_FRAC = DefSampleFrac,
    parameter int unsigned THRESH_FRAC = DefThreshFrac
) (
    input  logic [N-1:0] s_data_i,
    input  logic [N-1:0] thresh_hi_i,
    input  logic [N-1:0] thresh_lo_i,
    output logic [N-1:0] norm_sample_o,
    output logic         gt_hi_o,
    output logic         lt_lo_o
);

    localparam int unsigned SShift = sample_shift(SAMPLE_FRAC, THRESH_FRAC);
    localparam int unsigned TShift = thresh_shift(SAMPLE_FRAC, THRESH_FRAC);

    logic [N-1:0] norm_hi;
    logic [N-1:0] norm_lo;

    // Truncating shift: extra fraction bits of the finer operand are dropped.
    assign norm_sample_o = s_data_i >> SShift;
    assign norm_hi       = thresh_hi_i >> TShift;
    assign norm_lo       = thresh_lo_i >> TShift;

    assign gt_hi_o = norm_sample_o > norm_hi;
    assign lt_lo_o = norm_sample_o < norm_lo;

endmodule

// File: rtl/ufp_threshold_monitor.sv
// Threshold monitor: aligned compare stage, hysteresis/debounce FSM and a
// valid/ready event record carrying the peak sample seen while in alarm.
module ufp_threshold_monitor
    import ufp_mon_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned SAMPLE_FRAC = DefSampleFrac,
    parameter int unsigned THRESH_FRAC = DefThreshFrac,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [N-1:0] s_data_i,
    input  logic [N-1:0] thresh_hi_i,
    input  logic [N-1:0] thresh_lo_i,
    output logic         alarm_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic         m_rise_o,
    output logic [N-1:0] m_peak_o
);

    localparam logic [CNT_W-1:0] DebCnt = CNT_W'(DEBOUNCE);

    logic [N-1:0] norm_sample;
    logic         gt_hi;
    logic         lt_lo;

    ufp_align_cmp #(
        .N           (N),
        .SAMPLE_FRAC (SAMPLE_FRAC),
        .THRESH_FRAC (THRESH_FRAC)
    ) u_align_cmp (
        .s_data_i      (s_data_i),
        .thresh_hi_i   (thresh_hi_i),
        .thresh_lo_i   (thresh_lo_i),
        .norm_sample_o (norm_sample),
        .gt_hi_o       (gt_hi),
        .lt_lo_o       (lt_lo)
    );

    logic         st1_valid_q;
    logic [N-1:0] st1_sample_q;
    logic         st1_gt_q;
    logic         st1_lt_q;

    mon_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]   peak_q;
    logic           alarm_q;
    logic           m_valid_q;
    logic           m_rise_q;
    logic [N-1:0]   m_peak_q;

    logic           stall;
    logic           accept;
    logic           consume;
    logic [N-1:0]   peak_upd;
    logic [CNT_W-1:0] cnt_inc;

    assign stall     = m_valid_q && !m_ready_i;
    assign s_ready_o = !st1_valid_q || !stall;
    assign accept    = s_valid_i && s_ready_o && !clear_i;
    assign consume   = st1_valid_q && !stall;
    assign peak_upd  = (st1_sample_q > peak_q) ? st1_sample_q : peak_q;
    assign cnt_inc   = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_valid_q  <= 1'b0;
            st1_sample_q <= '0;
            st1_gt_q     <= 1'b0;
            st1_lt_q     <= 1'b0;
        end else if (clear_i) begin
            st1_valid_q  <= 1'b0;
            st1_sample_q <= '0;
            st1_gt_q     <= 1'b0;
            st1_lt_q     <= 1'b0;
        end else if (accept) begin
            st1_valid_q  <= 1'b1;
            st1_sample_q <= norm_sample;
            st1_gt_q     <= gt_hi;
            st1_lt_q     <= lt_lo;
        end else if (consume) begin
            st1_valid_q  <= 1'b0;
        end
    end

    // Later assignments in the case body win over the handshake clear, so an
    // event emitted in the same cycle as a consume keeps m_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLow;
            cnt_q     <= '0;
            peak_q    <= '0;
            alarm_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_rise_q  <= 1'b0;
            m_peak_q  <= '0;
        end else if (clear_i) begin
            state_q   <= StLow;
            cnt_q     <= '0;
            peak_q    <= '0;
            alarm_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_rise_q  <= 1'b0;
            m_peak_q  <= '0;
        end else begin
            if (m_valid_q && m_ready_i) begin
                m_valid_q <= 1'b0;
            end
            if (consume) begin
                unique case (state_q)
                    StLow: begin
                        if (st1_gt_q) begin
                            peak_q <= st1_sample_q;
                            cnt_q  <= CNT_W'(1);
                            if (DEBOUNCE == 1) begin
                                state_q   <= StAlarm;
                                alarm_q   <= 1'b1;
                                m_valid_q <= 1'b1;
                                m_rise_q  <= 1'b1;
                                m_peak_q  <= st1_sample_q;
                            end else begin
                                state_q <= StPendHi;
                            end
                        end
                    end
                    StPendHi: begin
                        if (st1_gt_q) begin
                            peak_q <= peak_upd;
                            cnt_q  <= cnt_inc;
                            if (cnt_inc == DebCnt) begin
                                state_q   <= StAlarm;
                                alarm_q   <= 1'b1;
                                m_valid_q <= 1'b1;
                                m_rise_q  <= 1'b1;
                                m_peak_q  <= peak_upd;
                            end
                        end else begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                            peak_q  <= '0;
                        end
                    end
                    StAlarm: begin
                        peak_q <= peak_upd;
                        if (st1_lt_q) begin
                            cnt_q <= CNT_W'(1);
                            if (DEBOUNCE == 1) begin
                                state_q   <= StLow;
                                alarm_q   <= 1'b0;
                                peak_q    <= '0;
                                m_valid_q <= 1'b1;
                                m_rise_q  <= 1'b0;
                                m_peak_q  <= peak_upd;
                            end else begin
                                state_q <= StPendLo;
                            end
                        end
                    end
                    StPendLo: begin
                        peak_q <= peak_upd;
                        if (st1_lt_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == DebCnt) begin
                                state_q   <= StLow;
                                alarm_q   <= 1'b0;
                                cnt_q     <= '0;
                                peak_q    <= '0;
                                m_valid_q <= 1'b1;
                                m_rise_q  <= 1'b0;
                                m_peak_q  <= peak_upd;
                            end
                        end else begin
                            state_q <= StAlarm;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= StLow;
                    end
                endcase
            end
        end
    end

    assign alarm_o   = alarm_q;
    assign m_valid_o = m_valid_q;
    assign m_rise_o  = m_rise_q;
    assign m_peak_o  = m_peak_q;

endmodule
